// File: rtl/packet_checker_frame_assembler_pkg.sv
// Shared definitions for the packet checker frame assembler.
// Error bit indices, FSM state encoding and lane-order selectors.
package packet_checker_frame_assembler_pkg;

    localparam int ERR_OVERFLOW = 0;
    localparam int ERR_ABORT    = 1;
    localparam int ERR_OVERRUN  = 2;
    localparam int ERR_RUNT     = 3;

    localparam int ORDER_INDEXED = 0;
    localparam int ORDER_SHIFT   = 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

endpackage

// File: rtl/packet_checker_frame_pack.sv
// Combinational lane placement for the output slot.
// Maps the indexed working buffer to the selected lane order, zero-filling unused lanes.
module packet_checker_frame_pack
    import packet_checker_frame_assembler_pkg::*;
#(
    parameter int STAGES = 4,
    parameter int BYTE_W = 8,
    parameter int ORDER  = 0,
    localparam int LW    = $clog2(STAGES + 1)
) (
    input  logic [STAGES*BYTE_W-1:0] i_buf,
    input  logic [LW-1:0]            i_len,
    output logic [STAGES*BYTE_W-1:0] o_frame
);

    // Place byte k in lane k (indexed) or lane len-1-k (shift).
    always_comb begin
        o_frame = '0;
        for (int j = 0; j < STAGES; j++) begin
            int src;
            src = j;
            if (j < int'(i_len)) begin
                if (ORDER == ORDER_SHIFT) begin
                    src = int'(i_len) - 1 - j;
                end
                o_frame[j*BYTE_W +: BYTE_W] = i_buf[src*BYTE_W +: BYTE_W];
            end
        end
    end

endmodule

// File: rtl/packet_checker_frame_assembler.sv
// Frame assembler: collects a delimited byte stream into up to STAGES lanes
// and hands complete frames to a registered valid/ready output slot.
module packet_checker_frame_assembler
    import packet_checker_frame_assembler_pkg::*;
#(
    parameter int STAGES  = 4,
    parameter int BYTE_W  = 8,
    parameter int MIN_LEN = 1,
    parameter int ORDER   = 0,
    localparam int LW     = $clog2(STAGES + 1)
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_valid,
    input  logic                     i_sof,
    input  logic                     i_eof,
    input  logic [BYTE_W-1:0]        i_byte,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [STAGES*BYTE_W-1:0] o_frame,
    output logic [LW-1:0]            o_len,
    output logic [3:0]               o_err,
    output logic                     o_busy
);

    localparam logic [LW-1:0] FULL = LW'(STAGES);
    localparam logic [LW-1:0] MINL = LW'(MIN_LEN);
    localparam logic [LW-1:0] ONE  = LW'(1);

    state_t                   state_q;
    state_t                   state_n;
    logic [LW-1:0]            cnt_q;
    logic [LW-1:0]            cnt_n;
    logic [STAGES*BYTE_W-1:0] wbuf_q;
    logic [STAGES*BYTE_W-1:0] wbuf_n;
    logic [3:0]               err_n;
    logic                     start;
    logic                     done;
    logic [LW-1:0]            done_len;
    logic                     load;
    logic [STAGES*BYTE_W-1:0] pack_frame;

    // Next-state, buffer fill and error/completion decode for each beat.
    always_comb begin
        state_n  = state_q;
        cnt_n    = cnt_q;
        wbuf_n   = wbuf_q;
        err_n    = '0;
        start    = 1'b0;
        done     = 1'b0;
        done_len = '0;
        load     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (i_valid && i_sof) begin
                    start = 1'b1;
                end
            end
            ST_COLLECT: begin
                if (i_valid) begin
                    if (i_sof) begin
                        start            = 1'b1;
                        err_n[ERR_ABORT] = 1'b1;
                    end else if (cnt_q == FULL) begin
                        err_n[ERR_OVERFLOW] = 1'b1;
                        cnt_n               = '0;
                        state_n = i_eof ? ST_IDLE : ST_DISCARD;
                    end else begin
                        for (int k = 0; k < STAGES; k++) begin
                            if (k == int'(cnt_q)) begin
                                wbuf_n[k*BYTE_W +: BYTE_W] = i_byte;
                            end
                        end
                        cnt_n = cnt_q + ONE;
                        if (i_eof) begin
                            done     = 1'b1;
                            done_len = cnt_q + ONE;
                            cnt_n    = '0;
                            state_n  = ST_IDLE;
                        end
                    end
                end
            end
            ST_DISCARD: begin
                if (i_valid) begin
                    if (i_sof) begin
                        start = 1'b1;
                    end else if (i_eof) begin
                        state_n = ST_IDLE;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
            end
        endcase

        if (start) begin
            wbuf_n[BYTE_W-1:0] = i_byte;
            if (i_eof) begin
                done     = 1'b1;
                done_len = ONE;
                cnt_n    = '0;
                state_n  = ST_IDLE;
            end else begin
                cnt_n   = ONE;
                state_n = ST_COLLECT;
            end
        end

        if (done) begin
            if (done_len < MINL) begin
                err_n[ERR_RUNT] = 1'b1;
            end else if (!o_valid || i_ready) begin
                load = 1'b1;
            end else begin
                err_n[ERR_OVERRUN] = 1'b1;
            end
        end
    end

    packet_checker_frame_pack #(
        .STAGES (STAGES),
        .BYTE_W (BYTE_W),
        .ORDER  (ORDER)
    ) u_pack (
        .i_buf   (wbuf_n),
        .i_len   (done_len),
        .o_frame (pack_frame)
    );

    // FSM state, lane counter and working buffer.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            wbuf_q  <= '0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            wbuf_q  <= wbuf_n;
        end
    end

    // Output slot and registered error pulses.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_valid <= 1'b0;
            o_frame <= '0;
            o_len   <= '0;
            o_err   <= '0;
        end else begin
            o_err <= err_n;
            if (load) begin
                o_valid <= 1'b1;
                o_frame <= pack_frame;
                o_len   <= done_len;
            end else if (i_ready) begin
                o_valid <= 1'b0;
            end
        end
    end

    assign o_busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_packet_checker_frame_assembler.sv
// Self-checking bench for packet_checker_frame_assembler.
// Three instances share stimulus: indexed, shift order, and MIN_LEN=2.
module tb_packet_checker_frame_assembler;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_valid = 1'b0;
    logic       i_sof = 1'b0;
    logic       i_eof = 1'b0;
    logic [7:0] i_byte = '0;
    logic       i_ready = 1'b1;

    logic        ov  [3];
    logic [31:0] ofr [3];
    logic [2:0]  oln [3];
    logic [3:0]  oer [3];
    logic        obs [3];

    int checks = 0;
    int failures = 0;

    always #5 i_clk = ~i_clk;

    packet_checker_frame_assembler #(
        .STAGES(4), .BYTE_W(8), .MIN_LEN(1), .ORDER(0)
    ) u0 (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_sof(i_sof),
        .i_eof(i_eof), .i_byte(i_byte), .o_valid(ov[0]), .i_ready(i_ready),
        .o_frame(ofr[0]), .o_len(oln[0]), .o_err(oer[0]), .o_busy(obs[0])
    );

    packet_checker_frame_assembler #(
        .STAGES(4), .BYTE_W(8), .MIN_LEN(1), .ORDER(1)
    ) u1 (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_sof(i_sof),
        .i_eof(i_eof), .i_byte(i_byte), .o_valid(ov[1]), .i_ready(i_ready),
        .o_frame(ofr[1]), .o_len(oln[1]), .o_err(oer[1]), .o_busy(obs[1])
    );

    packet_checker_frame_assembler #(
        .STAGES(4), .BYTE_W(8), .MIN_LEN(2), .ORDER(0)
    ) u2 (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_sof(i_sof),
        .i_eof(i_eof), .i_byte(i_byte), .o_valid(ov[2]), .i_ready(i_ready),
        .o_frame(ofr[2]), .o_len(oln[2]), .o_err(oer[2]), .o_busy(obs[2])
    );

    // Reference model: per-instance frame queue plus in-frame/discard flags.
    int          m_order [3] = '{0, 1, 0};
    int          m_min   [3] = '{1, 1, 2};
    logic [7:0]  mq      [3][$];
    bit          m_in    [3];
    bit          m_drop  [3];
    bit          m_valid [3];
    logic [31:0] m_frame [3];
    int          m_len   [3];
    logic [3:0]  m_err   [3];

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic beat(input bit s, input bit e, input logic [7:0] b);
        i_valid = 1'b1;
        i_sof = s;
        i_eof = e;
        i_byte = b;
        tick();
    endtask

    task automatic idle();
        i_valid = 1'b0;
        i_sof = 1'b0;
        i_eof = 1'b0;
        tick();
    endtask

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            mq[d].delete();
            m_in[d] = 0;
            m_drop[d] = 0;
            m_valid[d] = 0;
            m_frame[d] = '0;
            m_len[d] = 0;
            m_err[d] = '0;
        end
    endtask

    task automatic model_step(input int d, input bit v, input bit s,
                              input bit e, input logic [7:0] b, input bit r);
        logic [3:0]  err;
        bit          done;
        bit          load;
        int          len;
        int          pos;
        logic [31:0] fr;
        err = '0;
        done = 0;
        load = 0;
        if (v) begin
            if (s) begin
                if (m_in[d]) err[1] = 1'b1;
                mq[d].delete();
                mq[d].push_back(b);
                m_in[d] = 1;
                m_drop[d] = 0;
                done = e;
            end else if (m_drop[d]) begin
                if (e) m_drop[d] = 0;
            end else if (m_in[d]) begin
                if (mq[d].size() == 4) begin
                    err[0] = 1'b1;
                    m_in[d] = 0;
                    m_drop[d] = !e;
                end else begin
                    mq[d].push_back(b);
                    done = e;
                end
            end
        end
        if (done) begin
            m_in[d] = 0;
            len = mq[d].size();
            if (len < m_min[d]) begin
                err[3] = 1'b1;
            end else if (!m_valid[d] || r) begin
                load = 1;
                fr = '0;
                for (int k = 0; k < len; k++) begin
                    pos = (m_order[d] == 1) ? (len - 1 - k) : k;
                    fr = fr | (32'(mq[d][k]) << (8 * pos));
                end
                m_frame[d] = fr;
                m_len[d] = len;
            end else begin
                err[2] = 1'b1;
            end
        end
        if (load) m_valid[d] = 1;
        else if (r) m_valid[d] = 0;
        m_err[d] = err;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        tick();
        tick();
        for (int d = 0; d < 3; d++) begin
            checks++;
            if ({ov[d], ofr[d], oln[d], oer[d], obs[d]} !== '0) begin
                failures++;
                $display("FAIL reset[%0d] got v=%b f=%h l=%0d e=%b b=%b want all 0",
                         d, ov[d], ofr[d], oln[d], oer[d], obs[d]);
            end
        end
        i_rst = 1'b0;
        tick();
    endtask

    task automatic test_order();
        i_ready = 1'b1;
        beat(1, 0, 8'hA1);
        beat(0, 0, 8'hB2);
        beat(0, 0, 8'hC3);
        beat(0, 1, 8'hD4);
        checks++;
        if (ov[0] !== 1'b1 || oln[0] !== 3'd4 || ofr[0] !== 32'hD4C3B2A1) begin
            failures++;
            $display("FAIL order_idx4 got v=%b l=%0d f=%h want 1 4 d4c3b2a1",
                     ov[0], oln[0], ofr[0]);
        end
        checks++;
        if (ov[1] !== 1'b1 || oln[1] !== 3'd4 || ofr[1] !== 32'hA1B2C3D4) begin
            failures++;
            $display("FAIL order_shift4 got v=%b l=%0d f=%h want 1 4 a1b2c3d4",
                     ov[1], oln[1], ofr[1]);
        end
        idle();
        checks++;
        if (ov[0] !== 1'b0) begin
            failures++;
            $display("FAIL slot_drain got %b want 0", ov[0]);
        end
        beat(1, 0, 8'h11);
        beat(0, 1, 8'h22);
        checks++;
        if (ov[1] !== 1'b1 || oln[1] !== 3'd2 || ofr[1] !== 32'h00001122) begin
            failures++;
            $display("FAIL order_shift2 got v=%b l=%0d f=%h want 1 2 00001122",
                     ov[1], oln[1], ofr[1]);
        end
        checks++;
        if (ofr[0] !== 32'h00002211) begin
            failures++;
            $display("FAIL order_idx2 got %h want 00002211", ofr[0]);
        end
    endtask

    task automatic test_single();
        beat(1, 1, 8'h5A);
        checks++;
        if (ov[0] !== 1'b1 || oln[0] !== 3'd1 || ofr[0] !== 32'h0000005A) begin
            failures++;
            $display("FAIL single got v=%b l=%0d f=%h want 1 1 0000005a",
                     ov[0], oln[0], ofr[0]);
        end
        checks++;
        if (oer[2] !== 4'b1000 || ov[2] !== 1'b0) begin
            failures++;
            $display("FAIL runt got e=%b v=%b want 1000 0", oer[2], ov[2]);
        end
        idle();
        checks++;
        if (oer[2] !== 4'b0000) begin
            failures++;
            $display("FAIL runt_pulse got %b want 0000", oer[2]);
        end
    endtask

    task automatic test_overflow();
        beat(1, 0, 8'h01);
        beat(0, 0, 8'h02);
        beat(0, 0, 8'h03);
        beat(0, 0, 8'h04);
        beat(0, 0, 8'h05);
        checks++;
        if (oer[0] !== 4'b0001 || obs[0] !== 1'b1) begin
            failures++;
            $display("FAIL overflow got e=%b b=%b want 0001 1", oer[0], obs[0]);
        end
        beat(0, 0, 8'h06);
        checks++;
        if (oer[0] !== 4'b0000) begin
            failures++;
            $display("FAIL overflow_pulse got %b want 0000", oer[0]);
        end
        beat(0, 1, 8'h07);
        checks++;
        if (obs[0] !== 1'b0 || ov[0] !== 1'b0) begin
            failures++;
            $display("FAIL discard_end got b=%b v=%b want 0 0", obs[0], ov[0]);
        end
        beat(1, 0, 8'h08);
        beat(0, 1, 8'h09);
        checks++;
        if (ov[0] !== 1'b1 || oln[0] !== 3'd2 || ofr[0] !== 32'h00000908) begin
            failures++;
            $display("FAIL after_overflow got v=%b l=%0d f=%h want 1 2 00000908",
                     ov[0], oln[0], ofr[0]);
        end
    endtask

    task automatic test_abort();
        beat(1, 0, 8'h01);
        beat(0, 0, 8'h02);
        beat(1, 0, 8'h03);
        checks++;
        if (oer[0] !== 4'b0010) begin
            failures++;
            $display("FAIL abort got %b want 0010", oer[0]);
        end
        beat(0, 1, 8'h04);
        checks++;
        if (ov[0] !== 1'b1 || oln[0] !== 3'd2 || ofr[0] !== 32'h00000403) begin
            failures++;
            $display("FAIL after_abort got v=%b l=%0d f=%h want 1 2 00000403",
                     ov[0], oln[0], ofr[0]);
        end
    endtask

    task automatic test_overrun();
        i_ready = 1'b1;
        idle();
        i_ready = 1'b0;
        beat(1, 0, 8'hAA);
        beat(0, 1, 8'hBB);
        idle();
        beat(1, 0, 8'hCC);
        beat(0, 1, 8'hDD);
        checks++;
        if (oer[0] !== 4'b0100) begin
            failures++;
            $display("FAIL overrun got %b want 0100", oer[0]);
        end
        checks++;
        if (ov[0] !== 1'b1 || oln[0] !== 3'd2 || ofr[0] !== 32'h0000BBAA) begin
            failures++;
            $display("FAIL overrun_hold got v=%b l=%0d f=%h want 1 2 0000bbaa",
                     ov[0], oln[0], ofr[0]);
        end
        beat(1, 0, 8'hEE);
        i_ready = 1'b1;
        beat(0, 1, 8'hFF);
        checks++;
        if (ov[0] !== 1'b1 || oer[0] !== 4'b0000 || ofr[0] !== 32'h0000FFEE) begin
            failures++;
            $display("FAIL replace got v=%b e=%b f=%h want 1 0000 0000ffee",
                     ov[0], oer[0], ofr[0]);
        end
    endtask

    task automatic test_reset_mid();
        i_ready = 1'b0;
        beat(1, 0, 8'h11);
        beat(0, 0, 8'h22);
        #2;
        i_rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({ov[d], ofr[d], oln[d], oer[d], obs[d]} !== '0) begin
                failures++;
                $display("FAIL reset_mid[%0d] got v=%b f=%h l=%0d e=%b b=%b want all 0",
                         d, ov[d], ofr[d], oln[d], oer[d], obs[d]);
            end
        end
        i_valid = 1'b0;
        tick();
        i_rst = 1'b0;
        i_ready = 1'b1;
        tick();
    endtask

    task automatic test_random();
        bit v, s, e, r;
        logic [7:0] b;
        i_valid = 1'b0;
        i_rst = 1'b1;
        tick();
        model_reset();
        i_rst = 1'b0;
        for (int n = 0; n < 600; n++) begin
            v = ($urandom_range(0, 9) < 7);
            s = ($urandom_range(0, 3) == 0);
            e = ($urandom_range(0, 9) < 3);
            r = ($urandom_range(0, 9) < 6);
            b = 8'($urandom);
            i_valid = v;
            i_sof = s;
            i_eof = e;
            i_byte = b;
            i_ready = r;
            @(posedge i_clk);
            for (int d = 0; d < 3; d++) model_step(d, v, s, e, b, r);
            #1;
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (ov[d] !== m_valid[d] || oer[d] !== m_err[d] ||
                    obs[d] !== (m_in[d] || m_drop[d]) ||
                    (m_valid[d] && (ofr[d] !== m_frame[d] ||
                                    oln[d] !== 3'(m_len[d])))) begin
                    failures++;
                    $display("FAIL random[%0d] n=%0d got v=%b e=%b b=%b f=%h l=%0d want v=%b e=%b b=%b f=%h l=%0d",
                             d, n, ov[d], oer[d], obs[d], ofr[d], oln[d],
                             m_valid[d], m_err[d], m_in[d] || m_drop[d],
                             m_frame[d], m_len[d]);
                end
            end
        end
        i_valid = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_order();
        test_single();
        test_overflow();
        test_abort();
        test_overrun();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
